memwrite_checker: RTL and testbench

//  Synthesisable, parametrised self-check monitor for processor memory-write traffic.

---
 rtl/mwchk_pkg.sv | 8 +
 rtl/mwchk_table.sv | 36 +++
 rtl/memwrite_checker.sv | 165 ++++++++++++++++
 tb/tb_memwrite_checker.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mwchk_pkg.sv
// Shared types for the memwrite_checker self-check monitor.
package mwchk_pkg;

  typedef enum logic [1:0] {IDLE, RUN, PASS, FAIL} state_t;

  typedef enum logic [1:0] {FC_NONE, FC_ADDR, FC_DATA, FC_TIMEOUT} fail_code_t;

endpackage

// File: rtl/mwchk_table.sv
// Expected-write table: DEPTH entries of (address, data), synchronous write,
// asynchronous read by index. Contents are deliberately not reset.
module mwchk_table #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned IDX_W  = 3,
  parameter int unsigned RIDX_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  widx,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [RIDX_W-1:0] ridx,
  output logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [ADDR_W-1:0] mem_addr [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];
  logic              rd_ok;

  always_ff @(posedge clk) begin
    if (we && (widx <= IDX_W'(DEPTH - 1))) begin
      mem_addr[widx] <= waddr;
      mem_data[widx] <= wdata;
    end
  end

  // Out-of-range reads return zero so an oversized entry count cannot alias.
  assign rd_ok = (ridx <= RIDX_W'(DEPTH - 1));
  assign raddr = rd_ok ? mem_addr[ridx[IDX_W-1:0]] : '0;
  assign rdata = rd_ok ? mem_data[ridx[IDX_W-1:0]] : '0;

endmodule

// File: rtl/memwrite_checker.sv
// Self-check monitor comparing core memory writes against an ordered table.
// Optional capture of the first offending write: define MWCHK_CAPTURE_EN.
module memwrite_checker
  import mwchk_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned TIMEOUT_CYC = 4096,
  localparam int unsigned IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic [CNT_W-1:0]  cfg_num,
  input  logic              ign_en,
  input  logic [ADDR_W-1:0] ign_addr,
  input  logic              start,
  input  logic              memwrite,
  input  logic [ADDR_W-1:0] dataadr,
  input  logic [DATA_W-1:0] writedata,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic [1:0]        fail_code,
  output logic [CNT_W-1:0]  match_cnt,
  output logic [ADDR_W-1:0] cap_addr,
  output logic [DATA_W-1:0] cap_data
);

  localparam int unsigned      CYC_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(TIMEOUT_CYC - 1);

  state_t            state, state_n;
  fail_code_t        fc, fc_n;
  logic [CNT_W-1:0]  num_q, match_cnt_q;
  logic              ign_en_q;
  logic [ADDR_W-1:0] ign_addr_q;
  logic [CYC_W-1:0]  cyc;
  logic [ADDR_W-1:0] exp_addr;
  logic [DATA_W-1:0] exp_data;
  logic              ign_hit, match_inc;
  logic              busy_n, done_n, pass_n, fail_n;

  mwchk_table #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W),
    .RIDX_W (CNT_W)
  ) u_table (
    .clk   (clk),
    .we    (cfg_we && (state == IDLE)),
    .widx  (cfg_idx),
    .waddr (cfg_addr),
    .wdata (cfg_data),
    .ridx  (match_cnt_q),
    .raddr (exp_addr),
    .rdata (exp_data)
  );

  assign ign_hit = ign_en_q && (dataadr == ign_addr_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      pass  <= 1'b0;
      fail  <= 1'b0;
    end else begin
      state <= state_n;
      busy  <= busy_n;
      done  <= done_n;
      pass  <= pass_n;
      fail  <= fail_n;
    end
  end

  // A real compare result on the timeout edge takes precedence over the timeout.
  always_comb begin
    state_n   = state;
    fc_n      = fc;
    match_inc = 1'b0;
    if (start) begin
      state_n = (cfg_num == '0) ? PASS : RUN;
    end else if (state == RUN) begin
      if (memwrite && !ign_hit) begin
        if (dataadr != exp_addr) begin
          state_n = FAIL;
          fc_n    = FC_ADDR;
        end else if (writedata != exp_data) begin
          state_n = FAIL;
          fc_n    = FC_DATA;
        end else begin
          match_inc = 1'b1;
          if ((match_cnt_q + CNT_W'(1)) == num_q) state_n = PASS;
        end
      end
      if ((state_n == RUN) && (cyc == CYC_LAST)) begin
        state_n = FAIL;
        fc_n    = FC_TIMEOUT;
      end
    end
  end

  always_comb begin
    busy_n = (state_n == RUN);
    pass_n = (state_n == PASS);
    fail_n = (state_n == FAIL);
    done_n = pass_n || fail_n;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      num_q       <= '0;
      ign_en_q    <= 1'b0;
      ign_addr_q  <= '0;
      match_cnt_q <= '0;
      cyc         <= '0;
      fc          <= FC_NONE;
    end else if (start) begin
      num_q       <= cfg_num;
      ign_en_q    <= ign_en;
      ign_addr_q  <= ign_addr;
      match_cnt_q <= '0;
      cyc         <= '0;
      fc          <= FC_NONE;
    end else if (state == RUN) begin
      cyc <= cyc + CYC_W'(1);
      fc  <= fc_n;
      if (match_inc) match_cnt_q <= match_cnt_q + CNT_W'(1);
    end
  end

  assign fail_code = fc;
  assign match_cnt = match_cnt_q;

`ifdef MWCHK_CAPTURE_EN
  logic [ADDR_W-1:0] cap_addr_q;
  logic [DATA_W-1:0] cap_data_q;

  always_ff @(posedge clk) begin
    if (reset || start) begin
      cap_addr_q <= '0;
      cap_data_q <= '0;
    end else if ((state == RUN) && (state_n == FAIL)) begin
      cap_addr_q <= (fc_n == FC_TIMEOUT) ? '0 : dataadr;
      cap_data_q <= (fc_n == FC_TIMEOUT) ? '0 : writedata;
    end
  end

  assign cap_addr = cap_addr_q;
  assign cap_data = cap_data_q;
`else
  assign cap_addr = '0;
  assign cap_data = '0;
`endif

endmodule

// File: tb/tb_memwrite_checker.sv
// Self-checking bench for memwrite_checker: directed cases plus random write
// streams scored against a list-walking reference model.
module tb_memwrite_checker;

  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned TO    = 50;
  localparam int unsigned IW    = 2;
  localparam int unsigned CW    = 3;
  localparam int unsigned NE    = TO + 4;
`ifdef MWCHK_CAPTURE_EN
  localparam bit CAP_EN = 1'b1;
`else
  localparam bit CAP_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset, cfg_we, ign_en, start, memwrite;
  logic [IW-1:0] cfg_idx;
  logic [AW-1:0] cfg_addr, ign_addr, dataadr, cap_addr;
  logic [DW-1:0] cfg_data, writedata, cap_data;
  logic [CW-1:0] cfg_num, match_cnt;
  logic          busy, done, pass, fail;
  logic [1:0]    fail_code;

  int checks = 0;
  int errors = 0;

  logic [AW-1:0] exp_a [DEPTH];
  logic [DW-1:0] exp_d [DEPTH];
  bit            wr_en [NE];
  logic [AW-1:0] wr_a  [NE];
  logic [DW-1:0] wr_d  [NE];

  int            m_end, m_code, m_cnt;
  bit            m_pass;
  logic [AW-1:0] m_ca;
  logic [DW-1:0] m_cd;

  memwrite_checker #(
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .DEPTH       (DEPTH),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cfg_we    (cfg_we),
    .cfg_idx   (cfg_idx),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .cfg_num   (cfg_num),
    .ign_en    (ign_en),
    .ign_addr  (ign_addr),
    .start     (start),
    .memwrite  (memwrite),
    .dataadr   (dataadr),
    .writedata (writedata),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .fail      (fail),
    .fail_code (fail_code),
    .match_cnt (match_cnt),
    .cap_addr  (cap_addr),
    .cap_data  (cap_data)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic prog(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cfg_we   = 1'b1;
    cfg_idx  = IW'(i);
    cfg_addr = a;
    cfg_data = d;
    exp_a[i] = a;
    exp_d[i] = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic clr_wr();
    for (int e = 0; e < NE; e++) begin
      wr_en[e] = 1'b0;
      wr_a[e]  = '0;
      wr_d[e]  = '0;
    end
  endtask

  // Walk the write list in order; the first non-ignored write that disagrees
  // with the next table entry ends the run, otherwise the deadline does.
  task automatic model(input int num, input bit ien, input logic [AW-1:0] iaddr);
    m_cnt = 0; m_code = 0; m_ca = '0; m_cd = '0; m_pass = 1'b1; m_end = 0;
    if (num == 0) return;
    for (int e = 1; e <= TO; e++) begin
      if (!wr_en[e] || (ien && wr_a[e] == iaddr)) continue;
      m_end = e;
      if (wr_a[e] != exp_a[m_cnt]) begin
        m_pass = 1'b0; m_code = 1; m_ca = wr_a[e]; m_cd = wr_d[e];
        return;
      end
      if (wr_d[e] != exp_d[m_cnt]) begin
        m_pass = 1'b0; m_code = 2; m_ca = wr_a[e]; m_cd = wr_d[e];
        return;
      end
      m_cnt++;
      if (m_cnt == num) return;
    end
    m_end = TO; m_pass = 1'b0; m_code = 3;
  endtask

  task automatic run_scn(input int num, input bit ien, input logic [AW-1:0] iaddr, input string tag);
    model(num, ien, iaddr);
    cfg_num  = CW'(num);
    ign_en   = ien;
    ign_addr = iaddr;
    start    = 1'b1;
    memwrite = 1'b0;
    tick();
    start    = 1'b0;
    // Latched copies must be used, so scramble the live config inputs.
    ign_en   = ~ien;
    ign_addr = ~iaddr;
    cfg_num  = CW'($urandom_range(0, DEPTH));
    check({tag, ":busy0"}, busy, m_end > 0);
    for (int e = 1; e < NE; e++) begin
      memwrite  = wr_en[e];
      dataadr   = wr_a[e];
      writedata = wr_d[e];
      tick();
      check({tag, ":busy"}, busy, e < m_end);
    end
    memwrite = 1'b0;
    check({tag, ":pass"}, pass, m_pass);
    check({tag, ":fail"}, fail, !m_pass);
    check({tag, ":done"}, done, 1'b1);
    check({tag, ":code"}, fail_code, m_code);
    check({tag, ":mcnt"}, match_cnt, m_cnt);
    check({tag, ":cap_addr"}, cap_addr, CAP_EN ? m_ca : '0);
    check({tag, ":cap_data"}, cap_data, CAP_EN ? m_cd : '0);
  endtask

  task automatic check_idle(input string tag);
    check({tag, ":busy"}, busy, 1'b0);
    check({tag, ":done"}, done, 1'b0);
    check({tag, ":pass"}, pass, 1'b0);
    check({tag, ":fail"}, fail, 1'b0);
    check({tag, ":code"}, fail_code, 2'd0);
    check({tag, ":mcnt"}, match_cnt, 3'd0);
    check({tag, ":cap_addr"}, cap_addr, 32'd0);
    check({tag, ":cap_data"}, cap_data, 32'd0);
  endtask

  initial begin
    logic [AW-1:0] a, ia;
    logic [DW-1:0] d;
    int cur, dens, r, num;
    bit ien;

    reset = 1'b1; cfg_we = 1'b0; cfg_idx = '0; cfg_addr = '0; cfg_data = '0;
    cfg_num = '0; ign_en = 1'b0; ign_addr = '0; start = 1'b0;
    memwrite = 1'b0; dataadr = '0; writedata = '0;
    clr_wr();
    tick();
    tick();
    reset = 1'b0;
    check_idle("reset");

    // T1: scratch writes ignored, single matching write passes.
    prog(0, 32'd84, 32'hFFFF_FFC0);
    clr_wr();
    wr_en[2] = 1'b1; wr_a[2] = 32'd80; wr_d[2] = 32'd7;
    wr_en[4] = 1'b1; wr_a[4] = 32'd80; wr_d[4] = 32'd3;
    wr_en[6] = 1'b1; wr_a[6] = 32'd84; wr_d[6] = 32'hFFFF_FFC0;
    run_scn(1, 1'b1, 32'd80, "T1");

    // T2: wrong address.
    clr_wr();
    wr_en[3] = 1'b1; wr_a[3] = 32'd88; wr_d[3] = 32'd5;
    run_scn(1, 1'b1, 32'd80, "T2");

    // T3: wrong data, later correct write must not revive the run.
    clr_wr();
    wr_en[2] = 1'b1; wr_a[2] = 32'd84; wr_d[2] = 32'hFFFF_FFC1;
    wr_en[5] = 1'b1; wr_a[5] = 32'd84; wr_d[5] = 32'hFFFF_FFC0;
    run_scn(1, 1'b0, '0, "T3");

    // Start beats a mismatching write on the same edge and clears the result.
    cfg_num = 3'd1; start = 1'b1; memwrite = 1'b1; dataadr = 32'd999; writedata = 32'd9;
    tick();
    start = 1'b0; memwrite = 1'b0;
    check("prio:busy", busy, 1'b1);
    check("prio:fail", fail, 1'b0);
    check("prio:code", fail_code, 2'd0);
    check("prio:cap_addr", cap_addr, 32'd0);

    // T4: no writes -> timeout after exactly TO busy cycles.
    clr_wr();
    run_scn(1, 1'b0, '0, "T4");

    // T5: final match on the timeout edge wins; one edge later is too late.
    do_reset();
    prog(0, 32'd4, 32'd1);
    prog(1, 32'd8, 32'd2);
    clr_wr();
    wr_en[3] = 1'b1; wr_a[3] = 32'd4; wr_d[3] = 32'd1;
    wr_en[TO] = 1'b1; wr_a[TO] = 32'd8; wr_d[TO] = 32'd2;
    run_scn(2, 1'b0, '0, "T5");
    wr_en[TO] = 1'b0;
    wr_en[TO+1] = 1'b1; wr_a[TO+1] = 32'd8; wr_d[TO+1] = 32'd2;
    run_scn(2, 1'b0, '0, "T5late");

    // T6: reset mid-run discards progress, table survives, rerun passes.
    cfg_num = 3'd2; ign_en = 1'b0; start = 1'b1;
    tick();
    start = 1'b0; memwrite = 1'b1; dataadr = 32'd4; writedata = 32'd1;
    tick();
    memwrite = 1'b0;
    check("T6:mid_mcnt", match_cnt, 3'd1);
    do_reset();
    check_idle("T6:reset");
    clr_wr();
    wr_en[2] = 1'b1; wr_a[2] = 32'd4; wr_d[2] = 32'd1;
    wr_en[5] = 1'b1; wr_a[5] = 32'd8; wr_d[5] = 32'd2;
    run_scn(2, 1'b0, '0, "T6");

    // T7: table write with start lands; table write during RUN is dropped.
    do_reset();
    cfg_we = 1'b1; cfg_idx = 2'd0; cfg_addr = 32'd100; cfg_data = 32'd1;
    cfg_num = 3'd1; start = 1'b1;
    tick();
    start = 1'b0; cfg_addr = 32'd200; cfg_data = 32'd2;
    tick();
    cfg_we = 1'b0; memwrite = 1'b1; dataadr = 32'd100; writedata = 32'd1;
    tick();
    memwrite = 1'b0;
    check("T7:pass", pass, 1'b1);
    check("T7:mcnt", match_cnt, 3'd1);

    // T8: zero entries passes straight from start.
    clr_wr();
    wr_en[1] = 1'b1; wr_a[1] = 32'd12; wr_d[1] = 32'd12;
    run_scn(0, 1'b0, '0, "T8");

    // Randomised runs.
    for (int it = 0; it < 30; it++) begin
      do_reset();
      for (int i = 0; i < DEPTH; i++) begin
        a = {27'd0, 3'($urandom_range(0, 7)), 2'b00};
        d = DW'($urandom_range(0, 3));
        prog(i, a, d);
      end
      num  = $urandom_range(0, DEPTH);
      ien  = 1'($urandom_range(0, 1));
      ia   = {27'd0, 3'($urandom_range(0, 7)), 2'b00};
      dens = $urandom_range(5, 40);
      cur  = 0;
      clr_wr();
      for (int e = 1; e < NE; e++) begin
        if ($urandom_range(0, 99) < dens) begin
          r = $urandom_range(0, 99);
          wr_en[e] = 1'b1;
          if (r < 60 && cur < DEPTH) begin
            wr_a[e] = exp_a[cur]; wr_d[e] = exp_d[cur]; cur++;
          end else if (r < 75) begin
            wr_a[e] = ia; wr_d[e] = $urandom;
          end else if (r < 90) begin
            wr_a[e] = {27'd0, 3'($urandom_range(0, 7)), 2'b00};
            wr_d[e] = DW'($urandom_range(0, 3));
          end else begin
            wr_a[e] = exp_a[(cur < DEPTH) ? cur : 0];
            wr_d[e] = exp_d[(cur < DEPTH) ? cur : 0] ^ 32'd1;
          end
        end
      end
      run_scn(num, ien, ia, $sformatf("R%0d", it));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
